// File: rtl/fofb_link_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : fofb_link_frame_assembler
// Brief    : Packs the FOFB read-links byte stream into BYTES_PER_FRAME-byte
//            words (first byte MS) with saturating framing-fault counters.
//            Optional: FOFB_FRAME_ASSEMBLER_CHECKSUM_EN (last byte = XOR csum).
// Revision : 1.0 - initial release
// ============================================================================
module fofb_link_frame_assembler #(
  parameter int BYTES_PER_FRAME = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [7:0]                   s_tdata,
  input  logic                         s_tuser,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [8*BYTES_PER_FRAME-1:0] m_tdata,
  output logic                         m_tuser,
  output logic [COUNT_WIDTH-1:0]       frame_count,
  output logic [COUNT_WIDTH-1:0]       restart_count,
  output logic [COUNT_WIDTH-1:0]       orphan_count
`ifdef FOFB_FRAME_ASSEMBLER_CHECKSUM_EN
  ,
  output logic [COUNT_WIDTH-1:0]       csum_err_count
`endif
);

  localparam int                 c_idx_w    = $clog2(BYTES_PER_FRAME);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(BYTES_PER_FRAME - 1);
  localparam logic [c_idx_w-1:0] c_one_idx  = c_idx_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t                         r_state;
  logic [c_idx_w-1:0]             r_idx;
  // Holds the bytes already received; old bytes shift out toward the MS end.
  logic [8*(BYTES_PER_FRAME-1)-1:0] r_buf;
  logic                           w_accept;
  logic [8*BYTES_PER_FRAME-1:0]   w_shift;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign s_tready = (r_state != ST_FULL);
  assign w_accept = s_tvalid & s_tready;
  assign w_shift  = {r_buf, s_tdata};

`ifdef FOFB_FRAME_ASSEMBLER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_csum         <= '0;
      m_tuser        <= 1'b0;
      csum_err_count <= '0;
    end else begin
      if (w_accept && (s_tuser || r_state == ST_IDLE)) begin
        r_csum <= s_tdata;
      end else if (w_accept && r_state == ST_COLLECT) begin
        r_csum <= r_csum ^ s_tdata;
      end
      if (w_accept && r_state == ST_COLLECT && !s_tuser && r_idx == c_last_idx) begin
        m_tuser <= (r_csum != s_tdata);
      end
      if (r_state == ST_FULL && m_tready && m_tuser) begin
        csum_err_count <= sat_inc(csum_err_count);
      end
    end
  end
`else
  assign m_tuser = 1'b0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_buf         <= '0;
      m_tvalid      <= 1'b0;
      m_tdata       <= '0;
      frame_count   <= '0;
      restart_count <= '0;
      orphan_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (s_tuser) begin
              r_buf   <= w_shift[8*(BYTES_PER_FRAME-1)-1:0];
              r_idx   <= c_one_idx;
              r_state <= ST_COLLECT;
            end else begin
              orphan_count <= sat_inc(orphan_count);
            end
          end
        end
        ST_COLLECT: begin
          if (w_accept) begin
            r_buf <= w_shift[8*(BYTES_PER_FRAME-1)-1:0];
            // An early start-of-frame wins even on the expected last byte.
            if (s_tuser) begin
              restart_count <= sat_inc(restart_count);
              r_idx         <= c_one_idx;
            end else if (r_idx == c_last_idx) begin
              m_tdata  <= w_shift;
              m_tvalid <= 1'b1;
              r_idx    <= '0;
              r_state  <= ST_FULL;
            end else begin
              r_idx <= r_idx + c_one_idx;
            end
          end
        end
        ST_FULL: begin
          if (m_tready) begin
            m_tvalid    <= 1'b0;
            frame_count <= sat_inc(frame_count);
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fofb_link_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fofb_link_frame_assembler
// Brief    : Directed + randomized bench with a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fofb_link_frame_assembler;

  localparam int BPF = 4;
  localparam int CW  = 4;

  logic             clk = 1'b0;
  logic             arst;
  logic             s_tvalid, s_tready, s_tuser;
  logic [7:0]       s_tdata;
  logic             m_tvalid, m_tready, m_tuser;
  logic [8*BPF-1:0] m_tdata;
  logic [CW-1:0]    frame_count, restart_count, orphan_count;
`ifdef FOFB_FRAME_ASSEMBLER_CHECKSUM_EN
  logic [CW-1:0]    csum_err_count;
`endif

  fofb_link_frame_assembler #(.BYTES_PER_FRAME(BPF), .COUNT_WIDTH(CW)) dut (
    .clk           (clk),
    .arst          (arst),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tdata       (s_tdata),
    .s_tuser       (s_tuser),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tdata       (m_tdata),
    .m_tuser       (m_tuser),
    .frame_count   (frame_count),
    .restart_count (restart_count),
    .orphan_count  (orphan_count)
`ifdef FOFB_FRAME_ASSEMBLER_CHECKSUM_EN
    ,
    .csum_err_count(csum_err_count)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a pending output word plus the bytes of the open frame.
  bit         mdl_valid, mdl_user, mdl_in_frame;
  logic [31:0] mdl_data;
  int         mdl_fc, mdl_rc, mdl_oc, mdl_ec;
  logic [7:0] mdl_cur[$];
  logic [8:0] sq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= (1 << CW) - 1) ? x : x + 1;
  endfunction

  task automatic model_reset();
    mdl_valid = 0; mdl_user = 0; mdl_in_frame = 0; mdl_data = '0;
    mdl_fc = 0; mdl_rc = 0; mdl_oc = 0; mdl_ec = 0;
    mdl_cur.delete();
  endtask

  task automatic check_outputs();
    chk("m_tvalid", m_tvalid, mdl_valid);
    chk("m_tdata", m_tdata, mdl_data);
    chk("m_tuser", m_tuser, mdl_user);
    chk("frame_count", frame_count, mdl_fc);
    chk("restart_count", restart_count, mdl_rc);
    chk("orphan_count", orphan_count, mdl_oc);
`ifdef FOFB_FRAME_ASSEMBLER_CHECKSUM_EN
    chk("csum_err_count", csum_err_count, mdl_ec);
`endif
  endtask

  task automatic tick(input bit v, input bit u, input logic [7:0] d, input bit rdy, output bit acc);
    logic [7:0] x;
    s_tvalid = v; s_tuser = u; s_tdata = d; m_tready = rdy;
    chk("s_tready", s_tready, !mdl_valid);
    acc = 0;
    if (mdl_valid) begin
      if (rdy) begin
        mdl_valid = 0;
        mdl_fc = sat(mdl_fc);
        if (mdl_user) mdl_ec = sat(mdl_ec);
      end
    end else if (v) begin
      acc = 1;
      if (u) begin
        if (mdl_in_frame) mdl_rc = sat(mdl_rc);
        mdl_cur.delete();
        mdl_cur.push_back(d);
        mdl_in_frame = 1;
      end else if (!mdl_in_frame) begin
        mdl_oc = sat(mdl_oc);
      end else begin
        mdl_cur.push_back(d);
        if (mdl_cur.size() == BPF) begin
          mdl_data = '0;
          x = '0;
          for (int i = 0; i < BPF; i++) mdl_data = (mdl_data << 8) | 32'(mdl_cur[i]);
          for (int i = 0; i < BPF - 1; i++) x = x ^ mdl_cur[i];
`ifdef FOFB_FRAME_ASSEMBLER_CHECKSUM_EN
          mdl_user = (x != mdl_cur[BPF-1]);
`else
          mdl_user = 0;
`endif
          mdl_valid = 1;
          mdl_in_frame = 0;
          mdl_cur.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic push(input bit u, input logic [7:0] d);
    sq.push_back({u, d});
  endtask

  task automatic drive(input int max_cycles, input bit rdy);
    bit acc;
    for (int i = 0; i < max_cycles && sq.size() > 0; i++) begin
      tick(1'b1, sq[0][8], sq[0][7:0], rdy, acc);
      if (acc) void'(sq.pop_front());
    end
  endtask

  task automatic drain(input int budget);
    drive(budget, 1'b1);
    chk("queue_drained", 64'(sq.size()), 64'd0);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'($urandom), rdy, acc);
  endtask

  task automatic apply_reset();
    arst = 1'b1;
    s_tvalid = 1'b0;
    #2;
    model_reset();
    sq.delete();
    check_outputs();
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    arst = 1'b1; s_tvalid = 0; s_tuser = 0; s_tdata = '0; m_tready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    arst = 1'b0;
    #1;
    chk("ready_after_reset", s_tready, 1'b1);

    // Basic frame
    push(1, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
    drain(10);
    chk("basic_tvalid", m_tvalid, 1'b1);
    chk("basic_tdata", m_tdata, 32'h11223344);
    idle(1, 1);
    chk("basic_frame_count", frame_count, 1);

    // Orphans then restart
    push(0, 8'hAA); push(0, 8'hBB);
    drain(10);
    chk("orphan_two", orphan_count, 2);
    push(1, 8'h01); push(0, 8'h02); push(1, 8'h03);
    push(0, 8'h04); push(0, 8'h05); push(0, 8'h06);
    drain(20);
    chk("restart_one", restart_count, 1);
    chk("restart_tdata", m_tdata, 32'h03040506);
    idle(1, 1);

    // Backpressure: frame complete, then 10 stalled cycles with bytes pending
    push(1, 8'hA1); push(0, 8'hA2); push(0, 8'hA3); push(0, 8'hA4);
    push(1, 8'hB1); push(0, 8'hB2); push(0, 8'hB3); push(0, 8'hB4);
    drive(14, 0);
    chk("bp_tvalid", m_tvalid, 1'b1);
    chk("bp_tready", s_tready, 1'b0);
    chk("bp_tdata_held", m_tdata, 32'hA1A2A3A4);
    drain(20);
    chk("bp_next_tdata", m_tdata, 32'hB1B2B3B4);
    idle(1, 1);
    chk("bp_frame_count", frame_count, 4);

    // Reset in the middle of a frame
    push(1, 8'hC1); push(0, 8'hC2);
    drain(10);
    apply_reset();
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_frame_count", frame_count, 0);
    push(1, 8'hDE); push(0, 8'hAD); push(0, 8'hBE); push(0, 8'hEF);
    drain(10);
    chk("rst_next_tdata", m_tdata, 32'hDEADBEEF);
    idle(1, 1);

    // Counter saturation
    for (int i = 0; i < 20; i++) push(0, 8'(i));
    drain(30);
    chk("orphan_saturated", orphan_count, 15);

`ifdef FOFB_FRAME_ASSEMBLER_CHECKSUM_EN
    push(1, 8'h12); push(0, 8'h34); push(0, 8'h56); push(0, 8'h70);
    drain(10);
    chk("csum_good_tuser", m_tuser, 1'b0);
    idle(1, 1);
    push(1, 8'h12); push(0, 8'h34); push(0, 8'h56); push(0, 8'h71);
    drain(10);
    chk("csum_bad_tuser", m_tuser, 1'b1);
    idle(1, 1);
    chk("csum_err_count", csum_err_count, 1);
`endif

    // Randomized traffic against the model
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 8'($urandom),
           $urandom_range(0, 2) != 0, acc);
    end
    idle(3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fofb_link_frame_assembler.md
Name: fofb_link_frame_assembler

Overview:
- Sits directly downstream of the FOFB read-links mux. Consumes its single-beat 8-bit AXI-Stream, where tuser[0]=1 marks the first byte of a frame.
- Collects BYTES_PER_FRAME bytes into one wide word and presents it on a registered AXI-Stream master.
- Keeps saturating diagnostic counters for framing faults.
- Backpressures the mux FIFO through s_tready while an assembled word is waiting.

Parameters:
- BYTES_PER_FRAME, 4, bytes per assembled frame; legal range 2..16.
- COUNT_WIDTH, 16, width of each diagnostic counter.

Ports:
- clk  input  1  single clock for the whole block; all ports are synchronous to it.
- arst  input  1  asynchronous active-high reset.
- s_tvalid  input  1  byte valid from mux.
- s_tready  output  1  byte accepted when s_tvalid & s_tready.
- s_tdata  input  8  byte from mux.
- s_tuser  input  1  start-of-frame marker.
- m_tvalid  output  1  assembled frame valid.
- m_tready  input  1  downstream ready.
- m_tdata  output  8*BYTES_PER_FRAME  assembled frame; first byte in the most-significant byte position.
- m_tuser  output  1  frame error flag (see Optional Feature).
- frame_count  output  COUNT_WIDTH  frames delivered (counted on m handshake).
- restart_count  output  COUNT_WIDTH  frames aborted by an early start-of-frame.
- orphan_count  output  COUNT_WIDTH  bytes dropped while waiting for a start-of-frame.

Behaviour:
- Reset (arst=1, asynchronous):
  - State = IDLE; byte index = 0.
  - m_tvalid=0, m_tdata=0, m_tuser=0; all counters=0.
  - s_tready=1 one cycle after release.
  - A partial frame in progress when reset arrives is discarded.
- States: IDLE, COLLECT, FULL.
- s_tready = 1 in IDLE and COLLECT; 0 in FULL.
- IDLE, accepted byte:
  - s_tuser=1: store the byte in MS position, index=1, go to COLLECT.
  - s_tuser=0: drop the byte, orphan_count+1, stay in IDLE.
- COLLECT, accepted byte:
  - s_tuser=0: store at position index, index+1.
  - On storing index BYTES_PER_FRAME-1: load the output register, m_tvalid=1 next cycle, go to FULL.
  - s_tuser=1 (early start-of-frame): restart_count+1, discard the partial frame, store this byte as byte 0, index=1, stay in COLLECT.
- FULL:
  - Hold m_tdata/m_tuser stable while m_tvalid & !m_tready.
  - On m_tvalid & m_tready: m_tvalid=0 next cycle, frame_count+1, go to IDLE.
  - s_tready=0 throughout, so no byte is lost.
- Latency: last byte accepted in cycle N -> m_tvalid=1 in cycle N+1.
- Minimum frame period: BYTES_PER_FRAME+1 cycles when m_tready is held at 1.
- Unwritten byte positions are never output: every delivered frame is fully written.
- Counters saturate at 2^COUNT_WIDTH-1 and never wrap.
- Simultaneous increments of different counters are independent.
- s_tdata/s_tuser are ignored when s_tvalid=0.
- A start-of-frame on the exact cycle the last byte is expected is treated as a restart, not as completion.

Optional Feature:
- Macro: FOFB_FRAME_ASSEMBLER_CHECKSUM_EN.
- Defined:
  - The last byte of each frame is a checksum: XOR of bytes 0..BYTES_PER_FRAME-2.
  - The running XOR resets on every start-of-frame.
  - Mismatch: m_tuser=1 for that frame; the frame is still delivered.
  - Adds output csum_err_count (COUNT_WIDTH, saturating, reset 0), incremented at m handshake of a frame with m_tuser=1.
- Not defined: m_tuser is constant 0; the last byte is plain data; no csum_err_count port.

Test Plan:
- Basic frame: BYTES_PER_FRAME=4, m_tready=1; drive bytes 0x11(sof),0x22,0x33,0x44 back-to-back -> m_tdata=0x11223344, m_tvalid one cycle after 0x44, frame_count=1.
- Backpressure: complete a frame, hold m_tready=0 for 10 cycles while s_tvalid=1 with new bytes -> s_tready=0, m_tdata stable, no byte lost; raise m_tready -> next frame assembles intact.
- Orphan/restart:
  - Bytes 0xAA,0xBB with tuser=0 in IDLE -> orphan_count=2.
  - Then 0x01(sof),0x02,0x03(sof),0x04,0x05,0x06 -> restart_count=1, output 0x03040506.
- Reset mid-frame: assert arst after 2 of 4 bytes -> m_tvalid=0, counters 0; following full frame 0xDEADBEEF is output correctly.
- Saturation: COUNT_WIDTH=4, 20 orphan bytes -> orphan_count=15.
- Checksum (macro defined): frame 0x12,0x34,0x56,0x70 -> m_tuser=0; frame 0x12,0x34,0x56,0x71 -> m_tuser=1, csum_err_count=1.
